// File: rtl/gravsim_pkg.sv
// Shared types and address map for the GravSim body-state register file.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Address map: four global words followed by eleven per-body fields.
// Each field is laid out contiguously over all bodies.
package gravsim_pkg;

  // Per-body fields in address order.
  typedef enum logic [3:0] {
    F_MASS, F_RAD,
    F_POS_X, F_POS_Y, F_POS_Z,
    F_VEL_X, F_VEL_Y, F_VEL_Z,
    F_ACC_X, F_ACC_Y, F_ACC_Z
  } field_e;

  localparam int NUM_FIELDS = 11;

  // Global words sit below the per-body region.
  localparam int G          = 0;
  localparam int NUM        = G + 1;
  localparam int START      = NUM + 1;
  localparam int DONE       = START + 1;
  localparam int FIELD_BASE = DONE + 1;

  // Words zeroed per cycle by a sweep (matches the x/y/z acc triple).
  localparam int SWEEP_LANES = 3;

  typedef enum logic [1:0] {INIT, IDLE, CLEAR} sweep_state_e;

  function automatic int body_addr(input int field, input int body, input int max_bodies);
    return FIELD_BASE + field * max_bodies + body;
  endfunction

  function automatic int regfile_depth(input int max_bodies);
    return FIELD_BASE + NUM_FIELDS * max_bodies;
  endfunction

endpackage

// File: rtl/body_regfile_if.sv
// Bus bundle between the integration FSM / host and the body register file.
// Latency: reads return one cycle after acceptance; writes visible next cycle.
// Backpressure: fsm_ready gates FSM commands, host_waitrequest stalls the host.
//
// Ports: fsm_* = NGROUP triple-lane read/write groups, host_* = single-word
// Avalon-style port, clear_accs = acceleration sweep request, busy/addr_err = status.
interface body_regfile_if
  import gravsim_pkg::*;
#(
  parameter int MAX_BODIES = 10,
  parameter int NGROUP     = 2,
  parameter int DW         = 32
);
  localparam int DEPTH = regfile_depth(MAX_BODIES);
  localparam int AW    = $clog2(DEPTH);
  localparam int L     = 3 * NGROUP;

  logic [NGROUP-1:0]        fsm_re;
  logic [NGROUP-1:0]        fsm_we;
  logic [L-1:0][AW-1:0]     fsm_addr;
  logic [L-1:0][DW-1:0]     fsm_wdata;
  logic [L-1:0][DW-1:0]     fsm_rdata;
  logic                     fsm_ready;
  logic                     clear_accs;
  logic [AW-1:0]            host_addr;
  logic                     host_re;
  logic                     host_we;
  logic [DW-1:0]            host_wdata;
  logic [DW-1:0]            host_rdata;
  logic                     host_waitrequest;
  logic                     busy;
  logic                     addr_err;

  modport master (
    output fsm_re, fsm_we, fsm_addr, fsm_wdata, clear_accs,
           host_addr, host_re, host_we, host_wdata,
    input  fsm_rdata, fsm_ready, host_rdata, host_waitrequest, busy, addr_err
  );

  modport slave (
    input  fsm_re, fsm_we, fsm_addr, fsm_wdata, clear_accs,
           host_addr, host_re, host_we, host_wdata,
    output fsm_rdata, fsm_ready, host_rdata, host_waitrequest, busy, addr_err
  );

endinterface

// File: rtl/body_regfile_sweep_ctrl.sv
// Sweep sequencer: full zero sweep after reset, acceleration-only sweep on request.
// Latency: INIT ceil(DEPTH/3) cycles, CLEAR MAX_BODIES cycles; ready the cycle after.
// Backpressure: ready low while sweeping; clear requests during INIT are held.
//
// Ports: CLK/RESET, clear_accs (pulse), busy/ready status, and up to three
// sweep write lanes (sweep_we/sweep_addr) that always write zero.
module regfile_sweep_ctrl
  import gravsim_pkg::*;
#(
  parameter int MAX_BODIES = 10,
  parameter int DEPTH      = regfile_depth(MAX_BODIES),
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              clear_accs,
  output logic                              busy,
  output logic                              ready,
  output logic [SWEEP_LANES-1:0]            sweep_we,
  output logic [SWEEP_LANES-1:0][AW-1:0]    sweep_addr
);

  sweep_state_e  state, state_n;
  // Word pointer in INIT, body index in CLEAR.
  logic [AW-1:0] ptr, ptr_n;
  // Clear request seen during INIT, serviced once INIT finishes.
  logic          pend, pend_n;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= INIT;
      ptr   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      pend  <= pend_n;
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    pend_n     = pend;
    sweep_we   = '0;
    sweep_addr = '0;
    unique case (state)
      INIT: begin
        // The last group may straddle the end of storage; mask its tail.
        for (int i = 0; i < SWEEP_LANES; i++) begin
          if ((int'(ptr) + i) < DEPTH) begin
            sweep_we[i]   = 1'b1;
            sweep_addr[i] = AW'(int'(ptr) + i);
          end
        end
        if (clear_accs) pend_n = 1'b1;
        if ((int'(ptr) + SWEEP_LANES) >= DEPTH) begin
          ptr_n   = '0;
          pend_n  = 1'b0;
          state_n = (pend || clear_accs) ? CLEAR : IDLE;
        end else begin
          ptr_n = ptr + AW'(SWEEP_LANES);
        end
      end
      IDLE: begin
        if (clear_accs) begin
          state_n = CLEAR;
          ptr_n   = '0;
        end
      end
      CLEAR: begin
        // One body per cycle: ACC_X/Y/Z of body ptr.
        for (int i = 0; i < SWEEP_LANES; i++) begin
          sweep_we[i]   = 1'b1;
          sweep_addr[i] = AW'(body_addr(int'(F_ACC_X) + i, int'(ptr), MAX_BODIES));
        end
        if (int'(ptr) == MAX_BODIES - 1) begin
          state_n = IDLE;
          ptr_n   = '0;
        end else begin
          ptr_n = ptr + AW'(1);
        end
      end
      default: begin
        state_n = INIT;
        ptr_n   = '0;
        pend_n  = 1'b0;
      end
    endcase
  end

  assign busy  = (state != IDLE);
  assign ready = (state == IDLE);

endmodule

// File: rtl/body_regfile.sv
// Body-state register file: globals plus eleven per-body fields, FSM lanes and host port.
// Latency: reads registered, data one cycle after acceptance; writes visible next cycle.
// Backpressure: sweep > FSM > host; FSM holds while !fsm_ready, host holds on waitrequest.
//
// Ports: CLK, RESET (sync, active-high), bus (body_regfile_if.slave) carrying
// the FSM lane groups, host port, clear_accs request and busy/addr_err status.
module body_regfile
  import gravsim_pkg::*;
#(
  parameter int MAX_BODIES = 10,
  parameter int NGROUP     = 2,
  parameter int DW         = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  body_regfile_if.slave    bus
);

  localparam int DEPTH = regfile_depth(MAX_BODIES);
  localparam int AW    = $clog2(DEPTH);
  localparam int L     = 3 * NGROUP;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0]                       mem [DEPTH];

  logic                                ready;
  logic                                busy;
  logic [SWEEP_LANES-1:0]              sweep_we;
  logic [SWEEP_LANES-1:0][AW-1:0]      sweep_addr;

  logic [L-1:0][DW-1:0]                fsm_rdata_q;
  logic [DW-1:0]                       host_rdata_q;
  logic                                addr_err_q;

  logic                                fsm_cmd;
  logic                                host_go;
  logic                                host_ok;
  logic [L-1:0]                        lane_ok;
  logic                                err_now;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  regfile_sweep_ctrl #(
    .MAX_BODIES (MAX_BODIES),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_sweep (
    .CLK        (CLK),
    .RESET      (RESET),
    .clear_accs (bus.clear_accs),
    .busy       (busy),
    .ready      (ready),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  always_comb begin
    fsm_cmd = (|bus.fsm_re) || (|bus.fsm_we);
    // Host only gets the array when neither a sweep nor the FSM wants it.
    host_go = ready && !fsm_cmd && (bus.host_re || bus.host_we);
    host_ok = in_range(bus.host_addr);
    err_now = host_go && !host_ok;
    lane_ok = '0;
    for (int l = 0; l < L; l++) begin
      lane_ok[l] = in_range(bus.fsm_addr[l]);
      if (ready && (bus.fsm_re[l/3] || bus.fsm_we[l/3]) && !lane_ok[l]) err_now = 1'b1;
    end
  end

  // Storage has no reset; the INIT sweep defines it. Later statements win, so
  // higher lanes override lower ones on a collision. Sources never overlap in
  // time (arbitration), the ordering only settles lane-vs-lane collisions.
  always_ff @(posedge CLK) begin
    if (host_go && bus.host_we && host_ok) mem[bus.host_addr] <= bus.host_wdata;
    for (int l = 0; l < L; l++) begin
      if (ready && bus.fsm_we[l/3] && lane_ok[l]) mem[bus.fsm_addr[l]] <= bus.fsm_wdata[l];
    end
    for (int i = 0; i < SWEEP_LANES; i++) begin
      if (sweep_we[i]) mem[sweep_addr[i]] <= '0;
    end
  end

  // Read ports sample the pre-write contents, so a same-cycle read/write of
  // one address returns the old word.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fsm_rdata_q  <= '0;
      host_rdata_q <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      for (int l = 0; l < L; l++) begin
        if (ready && bus.fsm_re[l/3]) fsm_rdata_q[l] <= lane_ok[l] ? mem[bus.fsm_addr[l]] : '0;
      end
      // A combined re+we host command is treated as a write only.
      if (host_go && !bus.host_we && bus.host_re) host_rdata_q <= host_ok ? mem[bus.host_addr] : '0;
      if (err_now) addr_err_q <= 1'b1;
    end
  end

  assign bus.fsm_rdata        = fsm_rdata_q;
  assign bus.fsm_ready        = ready;
  assign bus.host_rdata       = host_rdata_q;
  assign bus.host_waitrequest = !ready || fsm_cmd;
  assign bus.busy             = busy;
  assign bus.addr_err         = addr_err_q;

endmodule

// File: tb/tb_body_regfile.sv
// Self-checking bench for body_regfile against an array-based reference model.
// Latency: reads expected one cycle after acceptance.
// Backpressure: bench holds commands until fsm_ready / !host_waitrequest.
module tb_body_regfile;

  localparam int MB    = 10;
  localparam int NG    = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 4 + 11 * MB;
  localparam int AW    = $clog2(DEPTH);
  localparam int L     = 3 * NG;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  body_regfile_if #(.MAX_BODIES(MB), .NGROUP(NG), .DW(DW)) bus ();

  body_regfile #(.MAX_BODIES(MB), .NGROUP(NG), .DW(DW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_rd [L];
  logic [31:0] exp_host;
  logic        exp_err;
  int          op_addr [3];
  logic [31:0] op_dat [3];

  function automatic int baddr(input int f, input int b);
    return 4 + f * MB + b;
  endfunction

  task automatic idle_inputs();
    bus.fsm_re = '0; bus.fsm_we = '0; bus.fsm_addr = '0; bus.fsm_wdata = '0;
    bus.clear_accs = 1'b0; bus.host_addr = '0; bus.host_re = 1'b0;
    bus.host_we = 1'b0; bus.host_wdata = '0;
  endtask

  task automatic model_zero();
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    for (int l = 0; l < L; l++) exp_rd[l] = '0;
    exp_host = '0;
    exp_err = 1'b0;
  endtask

  // Reads see the old contents, then writes apply in lane order.
  task automatic model_fsm(input int g, input logic re, input logic we);
    if (re) begin
      for (int k = 0; k < 3; k++) begin
        if (op_addr[k] < DEPTH) exp_rd[3*g+k] = model[op_addr[k]];
        else begin exp_rd[3*g+k] = '0; exp_err = 1'b1; end
      end
    end
    if (we) begin
      for (int k = 0; k < 3; k++) begin
        if (op_addr[k] < DEPTH) model[op_addr[k]] = op_dat[k];
        else exp_err = 1'b1;
      end
    end
  endtask

  task automatic fsm_op(input int g, input logic re, input logic we);
    int n = 0;
    bus.fsm_re = '0; bus.fsm_we = '0;
    bus.fsm_re[g] = re; bus.fsm_we[g] = we;
    for (int k = 0; k < 3; k++) begin
      bus.fsm_addr[3*g+k] = AW'(op_addr[k]);
      bus.fsm_wdata[3*g+k] = op_dat[k];
    end
    #1;
    while (!bus.fsm_ready && n < 200) begin @(negedge CLK); #1; n++; end
    if (n >= 200) begin checks++; failures++; $display("FAIL fsm_accept timeout group=%0d", g); end
    @(negedge CLK);
    model_fsm(g, re, we);
    bus.fsm_re = '0; bus.fsm_we = '0;
  endtask

  task automatic host_op(input int a, input logic re, input logic we, input logic [31:0] d);
    int n = 0;
    bus.host_addr = AW'(a); bus.host_re = re; bus.host_we = we; bus.host_wdata = d;
    #1;
    while (bus.host_waitrequest && n < 200) begin @(negedge CLK); #1; n++; end
    if (n >= 200) begin checks++; failures++; $display("FAIL host_accept timeout addr=%0d", a); end
    @(negedge CLK);
    if (we) begin
      if (a < DEPTH) model[a] = d; else exp_err = 1'b1;
    end else if (re) begin
      if (a < DEPTH) exp_host = model[a]; else begin exp_host = '0; exp_err = 1'b1; end
    end
    bus.host_re = 1'b0; bus.host_we = 1'b0;
  endtask

  task automatic read_word(input int a, output logic [31:0] d);
    host_op(a, 1'b1, 1'b0, '0);
    d = bus.host_rdata;
  endtask

  task automatic test_reset();
    int cnt = 0;
    logic [31:0] d;
    idle_inputs();
    RESET = 1'b1; @(negedge CLK); RESET = 1'b0;
    model_zero();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b want=1", bus.busy); end
    checks++; if (bus.fsm_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b want=0", bus.fsm_ready); end
    checks++; if (bus.host_waitrequest !== 1'b1) begin failures++; $display("FAIL rst_waitreq got=%b want=1", bus.host_waitrequest); end
    checks++; if (bus.addr_err !== 1'b0) begin failures++; $display("FAIL rst_addr_err got=%b want=0", bus.addr_err); end
    checks++; if (bus.host_rdata !== 32'h0) begin failures++; $display("FAIL rst_host_rdata got=%h want=0", bus.host_rdata); end
    checks++; if (bus.fsm_rdata !== '0) begin failures++; $display("FAIL rst_fsm_rdata got=%h want=0", bus.fsm_rdata); end
    while (bus.busy && cnt < 200) begin cnt++; @(negedge CLK); end
    checks++; if (cnt !== 38) begin failures++; $display("FAIL init_busy_cycles got=%0d want=38", cnt); end
    checks++; if (bus.fsm_ready !== 1'b1) begin failures++; $display("FAIL init_ready got=%b want=1", bus.fsm_ready); end
    for (int a = 0; a < DEPTH; a++) begin
      read_word(a, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL init_zero addr=%0d got=%h want=0", a, d); end
    end
  endtask

  task automatic test_host_fsm_read();
    host_op(baddr(2, 0), 1'b0, 1'b1, 32'h3f800000);
    host_op(baddr(2, 1), 1'b0, 1'b1, 32'hbf800000);
    op_addr = '{baddr(2, 0), baddr(2, 1), 0};
    op_dat  = '{32'h0, 32'h0, 32'h0};
    fsm_op(0, 1'b1, 1'b0);
    checks++; if (bus.fsm_rdata[0] !== 32'h3f800000) begin failures++; $display("FAIL rd_lane0 got=%h want=3f800000", bus.fsm_rdata[0]); end
    checks++; if (bus.fsm_rdata[1] !== 32'hbf800000) begin failures++; $display("FAIL rd_lane1 got=%h want=bf800000", bus.fsm_rdata[1]); end
    checks++; if (bus.fsm_rdata[2] !== 32'h0) begin failures++; $display("FAIL rd_lane2 got=%h want=0", bus.fsm_rdata[2]); end
    for (int l = 3; l < L; l++) begin
      checks++; if (bus.fsm_rdata[l] !== exp_rd[l]) begin failures++; $display("FAIL rd_hold lane=%0d got=%h want=%h", l, bus.fsm_rdata[l], exp_rd[l]); end
    end
  endtask

  task automatic test_clear_accs();
    int cnt = 0;
    logic [31:0] d;
    for (int b = 0; b < MB; b++) host_op(baddr(10, b), 1'b0, 1'b1, 32'hbf800000);
    for (int b = 0; b < MB; b++) begin
      op_addr = '{baddr(5, b), baddr(6, b), baddr(7, b)};
      op_dat  = '{$urandom, $urandom, $urandom};
      fsm_op(0, 1'b0, 1'b1);
      op_addr = '{baddr(8, b), baddr(9, b), baddr(1, b)};
      op_dat  = '{$urandom, $urandom, $urandom};
      fsm_op(1, 1'b0, 1'b1);
    end
    bus.clear_accs = 1'b1; @(negedge CLK); bus.clear_accs = 1'b0;
    while (bus.busy && cnt < 200) begin
      checks++; if (bus.fsm_ready !== 1'b0) begin failures++; $display("FAIL clear_ready_low cycle=%0d got=%b want=0", cnt, bus.fsm_ready); end
      cnt++; @(negedge CLK);
    end
    checks++; if (cnt !== MB) begin failures++; $display("FAIL clear_busy_cycles got=%0d want=%0d", cnt, MB); end
    for (int b = 0; b < MB; b++) for (int f = 8; f <= 10; f++) model[baddr(f, b)] = '0;
    for (int a = 0; a < DEPTH; a++) begin
      read_word(a, d);
      checks++; if (d !== model[a]) begin failures++; $display("FAIL clear_contents addr=%0d got=%h want=%h", a, d, model[a]); end
    end
  endtask

  task automatic test_host_wait();
    int ga [3];
    logic [31:0] gd [3];
    int ha;
    logic [31:0] hd, d;
    for (int k = 0; k < 3; k++) begin
      op_addr[k] = $urandom_range(4, DEPTH-1); op_dat[k] = $urandom;
      ga[k] = $urandom_range(4, DEPTH-1); gd[k] = $urandom;
      bus.fsm_addr[k] = AW'(op_addr[k]); bus.fsm_wdata[k] = op_dat[k];
      bus.fsm_addr[3+k] = AW'(ga[k]); bus.fsm_wdata[3+k] = gd[k];
    end
    ha = op_addr[0]; hd = $urandom;
    bus.fsm_we = 2'b11;
    bus.host_addr = AW'(ha); bus.host_we = 1'b1; bus.host_wdata = hd;
    #1;
    checks++; if (bus.host_waitrequest !== 1'b1) begin failures++; $display("FAIL wait_during_fsm got=%b want=1", bus.host_waitrequest); end
    @(negedge CLK);
    bus.fsm_we = '0;
    model_fsm(0, 1'b0, 1'b1);
    op_addr = ga; op_dat = gd;
    model_fsm(1, 1'b0, 1'b1);
    #1;
    checks++; if (bus.host_waitrequest !== 1'b0) begin failures++; $display("FAIL wait_after_fsm got=%b want=0", bus.host_waitrequest); end
    @(negedge CLK);
    bus.host_we = 1'b0;
    model[ha] = hd;
    read_word(ha, d);
    checks++; if (d !== hd) begin failures++; $display("FAIL host_after_fsm addr=%0d got=%h want=%h", ha, d, hd); end
    read_word(ga[2], d);
    checks++; if (d !== model[ga[2]]) begin failures++; $display("FAIL fsm_group1_write addr=%0d got=%h want=%h", ga[2], d, model[ga[2]]); end
  endtask

  task automatic test_collision_addr_err();
    int a;
    logic [31:0] d;
    a = baddr(0, 3);
    op_addr = '{a, baddr(1, 3), a};
    op_dat  = '{32'h1, $urandom, 32'h2};
    fsm_op(0, 1'b0, 1'b1);
    read_word(a, d);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL lane_collision got=%h want=2", d); end
    checks++; if (bus.addr_err !== 1'b0) begin failures++; $display("FAIL err_before got=%b want=0", bus.addr_err); end
    op_addr = '{120, 5, 6};
    op_dat  = '{$urandom, $urandom, $urandom};
    fsm_op(1, 1'b0, 1'b1);
    checks++; if (bus.addr_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b want=1", bus.addr_err); end
    op_addr = '{7, 125, 8};
    fsm_op(1, 1'b1, 1'b0);
    checks++; if (bus.fsm_rdata[4] !== 32'h0) begin failures++; $display("FAIL oor_read got=%h want=0", bus.fsm_rdata[4]); end
    checks++; if (bus.fsm_rdata[3] !== exp_rd[3]) begin failures++; $display("FAIL oor_neighbour got=%h want=%h", bus.fsm_rdata[3], exp_rd[3]); end
    repeat (5) @(negedge CLK);
    checks++; if (bus.addr_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", bus.addr_err); end
  endtask

  task automatic test_reset_mid_clear();
    int cnt = 0;
    logic [31:0] d;
    bus.clear_accs = 1'b1; @(negedge CLK); bus.clear_accs = 1'b0;
    @(negedge CLK);
    bus.clear_accs = 1'b1; @(negedge CLK); bus.clear_accs = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_clear_busy got=%b want=1", bus.busy); end
    RESET = 1'b1; @(negedge CLK); RESET = 1'b0;
    model_zero();
    checks++; if (bus.addr_err !== 1'b0) begin failures++; $display("FAIL rst2_addr_err got=%b want=0", bus.addr_err); end
    checks++; if (bus.fsm_rdata !== '0) begin failures++; $display("FAIL rst2_fsm_rdata got=%h want=0", bus.fsm_rdata); end
    while (bus.busy && cnt < 200) begin cnt++; @(negedge CLK); end
    checks++; if (cnt !== 38) begin failures++; $display("FAIL rst2_busy_cycles got=%0d want=38", cnt); end
    for (int i = 0; i < 6; i++) begin
      int a;
      a = $urandom_range(0, DEPTH-1);
      read_word(a, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst2_zero addr=%0d got=%h want=0", a, d); end
    end
  endtask

  task automatic test_clear_during_init();
    int cnt = 0;
    RESET = 1'b1; @(negedge CLK); RESET = 1'b0;
    model_zero();
    while (bus.busy && cnt < 200) begin
      cnt++;
      bus.clear_accs = (cnt == 5);
      @(negedge CLK);
    end
    bus.clear_accs = 1'b0;
    checks++; if (cnt !== 38 + MB) begin failures++; $display("FAIL init_then_clear_cycles got=%0d want=%0d", cnt, 38 + MB); end
    checks++; if (bus.fsm_ready !== 1'b1) begin failures++; $display("FAIL init_then_clear_ready got=%b want=1", bus.fsm_ready); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        int a;
        logic re, we;
        a  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(DEPTH, 127)) : int'($urandom_range(20, 35));
        re = 1'($urandom_range(0, 1));
        we = re ? 1'($urandom_range(0, 1)) : 1'b1;
        host_op(a, re, we, $urandom);
      end else begin
        int g;
        logic re, we;
        g = $urandom_range(0, NG-1);
        for (int k = 0; k < 3; k++) begin
          op_addr[k] = ($urandom_range(0, 15) == 0) ? int'($urandom_range(DEPTH, 127)) : int'($urandom_range(20, 35));
          op_dat[k]  = $urandom;
        end
        if ($urandom_range(0, 3) == 0) op_addr[2] = op_addr[0];
        re = 1'($urandom_range(0, 1));
        we = 1'($urandom_range(0, 1));
        if (!re && !we) re = 1'b1;
        fsm_op(g, re, we);
      end
      for (int l = 0; l < L; l++) begin
        checks++; if (bus.fsm_rdata[l] !== exp_rd[l]) begin failures++; $display("FAIL rand_fsm it=%0d lane=%0d got=%h want=%h", it, l, bus.fsm_rdata[l], exp_rd[l]); end
      end
      checks++; if (bus.host_rdata !== exp_host) begin failures++; $display("FAIL rand_host it=%0d got=%h want=%h", it, bus.host_rdata, exp_host); end
      checks++; if (bus.addr_err !== exp_err) begin failures++; $display("FAIL rand_err it=%0d got=%b want=%b", it, bus.addr_err, exp_err); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_host_fsm_read();
    test_clear_accs();
    test_host_wait();
    test_collision_addr_err();
    test_reset_mid_clear();
    test_clear_during_init();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
